// File: rtl/vdp_port_ctrl.sv
// CPU-side VDP port controller: command latch, auto-increment address,
// register file, read-ahead buffer, status flags and interrupt logic.
module vdp_port_ctrl #(
  parameter int ADDR_BITS = 14,
  parameter int NUM_REGS  = 11,
  parameter int CRAM_BITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  data_wr,
  input  logic                  data_rd,
  input  logic                  ctrl_wr,
  input  logic                  ctrl_rd,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  output logic [ADDR_BITS-1:0]  vram_addr,
  output logic                  vram_we,
  output logic [7:0]            vram_wdata,
  output logic                  vram_re,
  input  logic [7:0]            vram_rdata,
  output logic [CRAM_BITS-1:0]  cram_addr,
  output logic                  cram_we,
  output logic [NUM_REGS*8-1:0] regs_flat,
  input  logic                  frame_set,
  input  logic                  ovf_set,
  input  logic                  coll_set,
  input  logic                  line_tick,
  input  logic                  line_active,
  output logic                  irq_n
);

  localparam logic [ADDR_BITS-1:0] ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  logic [ADDR_BITS-1:0] addr_q, addr_d, setup_addr;
  logic [1:0]           code_q, code_d;
  logic [7:0]           latch_q, latch_d;
  logic [7:0]           rbuf_q, rbuf_d;
  logic                 pend_q, pend_d;
  logic                 pf_q, pf_d;
  logic                 frame_q, frame_d;
  logic                 ovf_q, ovf_d;
  logic                 coll_q, coll_d;
  logic                 line_f_q, line_f_d;
  logic [7:0]           line_cnt_q, line_cnt_d;
  logic                 irq_n_q, irq_n_d;
  logic [7:0]           regs_q [NUM_REGS];
  logic [7:0]           regs_d [NUM_REGS];

  logic cw, dw, dr, cr, setup;
  logic line_en, frame_en;
  logic [7:0] reg10;

  // Illegal coincident strobes resolve ctrl_wr > data_wr > data_rd > ctrl_rd
  assign cw = ctrl_wr;
  assign dw = data_wr & ~ctrl_wr;
  assign dr = data_rd & ~ctrl_wr & ~data_wr;
  assign cr = ctrl_rd & ~ctrl_wr & ~data_wr & ~data_rd;

  assign setup      = cw & pend_q;
  assign setup_addr = {din[ADDR_BITS-9:0], latch_q};

  assign line_en = regs_q[0][4];

  if (NUM_REGS > 1) begin : g_r1
    assign frame_en = regs_q[1][5];
  end else begin : g_nr1
    assign frame_en = 1'b0;
  end

  if (NUM_REGS > 10) begin : g_r10
    assign reg10 = regs_q[10];
  end else begin : g_nr10
    assign reg10 = 8'h00;
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign regs_flat[8*i +: 8] = regs_q[i];
  end

  assign vram_addr  = setup ? setup_addr : addr_q;
  assign vram_re    = dr | (setup & (din[7:6] == 2'd0));
  assign vram_we    = dw & (code_q != 2'd3);
  assign cram_we    = dw & (code_q == 2'd3);
  assign vram_wdata = din;
  assign cram_addr  = addr_q[CRAM_BITS-1:0];
  assign dout       = cr ? {frame_q, ovf_q, coll_q, 5'b11111} : rbuf_q;
  assign irq_n      = irq_n_q;

  always_comb begin
    addr_d     = addr_q;
    code_d     = code_q;
    latch_d    = latch_q;
    rbuf_d     = rbuf_q;
    pend_d     = pend_q;
    regs_d     = regs_q;
    line_cnt_d = line_cnt_q;
    pf_d       = vram_re;
    if (pf_q) rbuf_d = vram_rdata;
    unique case (1'b1)
      cw: begin
        if (!pend_q) begin
          latch_d     = din;
          addr_d[7:0] = din;
          pend_d      = 1'b1;
        end else begin
          code_d = din[7:6];
          pend_d = 1'b0;
          addr_d = setup_addr;
          if (din[7:6] == 2'd0) addr_d = setup_addr + ONE;
          if (din[7:6] == 2'd2 && 32'(din[3:0]) < NUM_REGS)
            regs_d[din[3:0]] = latch_q;
        end
      end
      dw: begin
        rbuf_d = din;
        addr_d = addr_q + ONE;
        pend_d = 1'b0;
      end
      dr: begin
        addr_d = addr_q + ONE;
        pend_d = 1'b0;
      end
      cr: pend_d = 1'b0;
      default: ;
    endcase
    // Set beats read-clear in the same cycle
    frame_d  = frame_set | (frame_q & ~cr);
    ovf_d    = ovf_set | (ovf_q & ~cr);
    coll_d   = coll_set | (coll_q & ~cr);
    line_f_d = line_f_q & ~cr;
    if (line_tick) begin
      if (!line_active) begin
        line_cnt_d = reg10;
      end else if (line_cnt_q == 8'd0) begin
        line_cnt_d = reg10;
        line_f_d   = 1'b1;
      end else begin
        line_cnt_d = line_cnt_q - 8'd1;
      end
    end
    irq_n_d = ~((frame_q & frame_en) | (line_f_q & line_en));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      code_q     <= '0;
      latch_q    <= '0;
      rbuf_q     <= '0;
      pend_q     <= 1'b0;
      pf_q       <= 1'b0;
      frame_q    <= 1'b0;
      ovf_q      <= 1'b0;
      coll_q     <= 1'b0;
      line_f_q   <= 1'b0;
      line_cnt_q <= '0;
      irq_n_q    <= 1'b1;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      addr_q     <= addr_d;
      code_q     <= code_d;
      latch_q    <= latch_d;
      rbuf_q     <= rbuf_d;
      pend_q     <= pend_d;
      pf_q       <= pf_d;
      frame_q    <= frame_d;
      ovf_q      <= ovf_d;
      coll_q     <= coll_d;
      line_f_q   <= line_f_d;
      line_cnt_q <= line_cnt_d;
      irq_n_q    <= irq_n_d;
      regs_q     <= regs_d;
    end
  end

endmodule

// File: tb/tb_vdp_port_ctrl.sv
// Bench for vdp_port_ctrl: transaction-level model plus directed
// literal checks and a randomized port traffic phase.
module tb_vdp_port_ctrl;

  localparam int AB = 14;
  localparam int NR = 11;
  localparam int CB = 5;

  logic clk = 0;
  logic reset = 1;
  logic data_wr = 0, data_rd = 0, ctrl_wr = 0, ctrl_rd = 0;
  logic [7:0] din = 0;
  logic [7:0] dout;
  logic [AB-1:0] vram_addr;
  logic vram_we, vram_re, cram_we;
  logic [7:0] vram_wdata;
  logic [7:0] vram_rdata = 0;
  logic [CB-1:0] cram_addr;
  logic [NR*8-1:0] regs_flat;
  logic frame_set = 0, ovf_set = 0, coll_set = 0;
  logic line_tick = 0, line_active = 0;
  logic irq_n;

  vdp_port_ctrl #(.ADDR_BITS(AB), .NUM_REGS(NR), .CRAM_BITS(CB)) dut (
    .clk(clk), .reset(reset),
    .data_wr(data_wr), .data_rd(data_rd),
    .ctrl_wr(ctrl_wr), .ctrl_rd(ctrl_rd),
    .din(din), .dout(dout),
    .vram_addr(vram_addr), .vram_we(vram_we),
    .vram_wdata(vram_wdata), .vram_re(vram_re),
    .vram_rdata(vram_rdata),
    .cram_addr(cram_addr), .cram_we(cram_we),
    .regs_flat(regs_flat),
    .frame_set(frame_set), .ovf_set(ovf_set), .coll_set(coll_set),
    .line_tick(line_tick), .line_active(line_active),
    .irq_n(irq_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  task automatic chk(input string nm, input logic [127:0] a,
                     input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // VRAM seen by the DUT
  logic [7:0] vram [16384];
  always @(posedge clk) begin
    if (vram_re) vram_rdata <= vram[vram_addr];
    if (vram_we) vram[vram_addr] = vram_wdata;
  end

  // Reference model state
  logic [7:0] m_vram [16384];
  int m_addr, m_code, m_cnt;
  logic [7:0] m_latch, m_rbuf, m_pf_val;
  bit m_pend, m_pf;
  bit m_frame, m_ovf, m_coll, m_line, m_irq_n;
  logic [7:0] m_regs [NR];

  always @(posedge clk) begin : model
    bit cw, dw, dr, cr;
    int na;
    logic [7:0] r10;
    if (reset) begin
      m_addr = 0; m_code = 0; m_cnt = 0;
      m_latch = 0; m_rbuf = 0; m_pend = 0; m_pf = 0;
      m_frame = 0; m_ovf = 0; m_coll = 0; m_line = 0;
      m_irq_n = 1;
      for (int i = 0; i < NR; i++) m_regs[i] = 0;
    end else begin
      m_irq_n = !((m_frame && m_regs[1][5]) || (m_line && m_regs[0][4]));
      cw = ctrl_wr;
      dw = data_wr && !cw;
      dr = data_rd && !cw && !data_wr;
      cr = ctrl_rd && !cw && !data_wr && !data_rd;
      r10 = m_regs[10];
      if (m_pf) begin m_rbuf = m_pf_val; m_pf = 0; end
      if (cw) begin
        if (!m_pend) begin
          m_latch = din;
          m_addr = (m_addr & ~255) | int'(din);
          m_pend = 1;
        end else begin
          m_code = int'(din[7:6]);
          m_pend = 0;
          na = (int'(din[5:0]) * 256) + int'(m_latch);
          m_addr = na;
          if (m_code == 0) begin
            m_pf = 1; m_pf_val = m_vram[na];
            m_addr = (na + 1) % 16384;
          end
          if (m_code == 2 && int'(din[3:0]) < NR) m_regs[din[3:0]] = m_latch;
        end
      end else if (dw) begin
        if (m_code != 3) m_vram[m_addr] = din;
        m_rbuf = din;
        m_addr = (m_addr + 1) % 16384;
        m_pend = 0;
      end else if (dr) begin
        m_pf = 1; m_pf_val = m_vram[m_addr];
        m_addr = (m_addr + 1) % 16384;
        m_pend = 0;
      end else if (cr) begin
        m_frame = 0; m_ovf = 0; m_coll = 0; m_line = 0;
        m_pend = 0;
      end
      if (frame_set) m_frame = 1;
      if (ovf_set) m_ovf = 1;
      if (coll_set) m_coll = 1;
      if (line_tick) begin
        if (!line_active) m_cnt = int'(r10);
        else if (m_cnt == 0) begin m_cnt = int'(r10); m_line = 1; end
        else m_cnt = m_cnt - 1;
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin : compare
    bit cw, dw, dr, cr, e_we, e_cwe, e_re;
    int ea;
    logic [NR*8-1:0] e_regs;
    if (chk_on && !reset) begin
      cw = ctrl_wr;
      dw = data_wr && !cw;
      dr = data_rd && !cw && !data_wr;
      cr = ctrl_rd && !cw && !data_wr && !data_rd;
      e_we  = dw && m_code != 3;
      e_cwe = dw && m_code == 3;
      e_re  = dr || (cw && m_pend && din[7:6] == 2'd0);
      ea = (cw && m_pend) ? int'(din[5:0]) * 256 + int'(m_latch) : m_addr;
      for (int i = 0; i < NR; i++) e_regs[8*i +: 8] = m_regs[i];
      chk("vram_we", vram_we, e_we);
      chk("cram_we", cram_we, e_cwe);
      chk("vram_re", vram_re, e_re);
      chk("dout", dout,
          cr ? {m_frame, m_ovf, m_coll, 5'b11111} : m_rbuf);
      chk("regs_flat", regs_flat, e_regs);
      chk("irq_n", irq_n, m_irq_n);
      if (e_we || e_re) chk("vram_addr", vram_addr, ea);
      if (e_we || e_cwe) chk("vram_wdata", vram_wdata, din);
      if (e_cwe) chk("cram_addr", cram_addr, m_addr % 32);
    end
  end

  logic [7:0] last_dout;
  logic [CB-1:0] last_cram;
  logic last_cwe;

  task automatic op(input int k, input logic [7:0] d, input bit fr = 0);
    @(posedge clk); #1;
    din = d;
    frame_set = fr;
    case (k)
      0: ctrl_wr = 1;
      1: data_wr = 1;
      2: data_rd = 1;
      default: ctrl_rd = 1;
    endcase
    #2;
    last_dout = dout;
    last_cram = cram_addr;
    last_cwe = cram_we;
    @(posedge clk); #1;
    {ctrl_wr, data_wr, data_rd, ctrl_rd} = '0;
    frame_set = 0;
    @(posedge clk);
  endtask

  task automatic pulse(input string nm, input bit fr, input bit lt,
                       input bit act, input bit e1, input bit e2);
    @(posedge clk); #1;
    frame_set = fr; line_tick = lt; line_active = act;
    @(posedge clk); #1;
    frame_set = 0; line_tick = 0;
    #1 chk({nm, "_irq_t1"}, irq_n, e1);
    @(posedge clk); #2;
    chk({nm, "_irq_t2"}, irq_n, e2);
  endtask

  initial begin
    int gap;
    for (int i = 0; i < 16384; i++) begin
      vram[i] = 8'($urandom);
      m_vram[i] = vram[i];
    end
    vram[16'h100] = 8'h11; m_vram[16'h100] = 8'h11;
    vram[16'h101] = 8'h22; m_vram[16'h101] = 8'h22;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    chk_on = 1;
    #1;
    chk("reset_dout", dout, 8'h00);
    chk("reset_irq", irq_n, 1'b1);
    chk("reset_regs", regs_flat, '0);

    op(0, 8'h60); op(0, 8'h81);
    #2 chk("reg1_60", regs_flat[15:8], 8'h60);
    chk("reg_irq_idle", irq_n, 1'b1);

    op(0, 8'h00); op(0, 8'h40);
    op(1, 8'hAA); op(1, 8'hBB);
    #2 chk("vram0", vram[0], 8'hAA);
    chk("vram1", vram[1], 8'hBB);
    chk("rbuf_bb", dout, 8'hBB);

    op(0, 8'h00); op(0, 8'h01);
    op(2, 8'h00);
    chk("readahead1", last_dout, 8'h11);
    op(2, 8'h00);
    chk("readahead2", last_dout, 8'h22);

    op(0, 8'h1F); op(0, 8'hC0);
    op(1, 8'h05);
    chk("cram_we1", last_cwe, 1'b1);
    chk("cram_a31", last_cram, 5'd31);
    op(1, 8'h06);
    chk("cram_a0", last_cram, 5'd0);

    op(0, 8'h20); op(0, 8'h81);
    pulse("frame", 1, 0, 0, 1, 0);
    op(3, 8'h00);
    chk("status_9f", last_dout, 8'h9F);
    #2 chk("irq_cleared", irq_n, 1'b1);
    op(3, 8'h00, 1);
    chk("status_race", last_dout, 8'h1F);
    #2 chk("race_irq", irq_n, 1'b0);
    op(3, 8'h00);
    chk("race_9f", last_dout, 8'h9F);

    op(0, 8'h10); op(0, 8'h80);
    op(0, 8'h02); op(0, 8'h8A);
    pulse("reload", 0, 1, 0, 1, 1);
    pulse("line1", 0, 1, 1, 1, 1);
    pulse("line2", 0, 1, 1, 1, 1);
    pulse("line3", 0, 1, 1, 1, 0);
    op(3, 8'h00);
    chk("line_status", last_dout, 8'h1F);
    #2 chk("line_irq_clr", irq_n, 1'b1);
    pulse("inact", 0, 1, 0, 1, 1);
    pulse("line4", 0, 1, 1, 1, 1);
    pulse("line5", 0, 1, 1, 1, 1);

    // Reset landing on the prefetch completion edge
    op(0, 8'h00); op(0, 8'h41);
    op(1, 8'h5A);
    @(posedge clk); #1 data_rd = 1;
    @(posedge clk); #1 data_rd = 0; reset = 1;
    @(posedge clk); #1 reset = 0;
    #1 chk("pf_reset_dout", dout, 8'h00);

    gap = 0;
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk); #1;
      {ctrl_wr, data_wr, data_rd, ctrl_rd} = '0;
      frame_set = ($urandom % 40) == 0;
      ovf_set = ($urandom % 60) == 0;
      coll_set = ($urandom % 60) == 0;
      line_tick = ($urandom % 8) == 0;
      line_active = ($urandom % 4) != 0;
      if (gap == 0 && ($urandom % 2) == 1) begin
        din = 8'($urandom);
        case ($urandom % 4)
          0: ctrl_wr = 1;
          1: data_wr = 1;
          2: data_rd = 1;
          default: ctrl_rd = 1;
        endcase
        if (($urandom % 16) == 0) begin
          case ($urandom % 4)
            0: ctrl_wr = 1;
            1: data_wr = 1;
            2: data_rd = 1;
            default: ctrl_rd = 1;
          endcase
        end
        gap = 1 + ($urandom % 2);
      end else if (gap > 0) begin
        gap--;
      end
    end
    @(posedge clk); #1;
    {ctrl_wr, data_wr, data_rd, ctrl_rd} = '0;
    {frame_set, ovf_set, coll_set, line_tick} = '0;
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
